// File: rtl/retire_pkg.sv
// rtl/retire_pkg.sv - shared retire record type for the retire pair buffer.
package retire_pkg;

  localparam int RETIRE_W = 32;

  // Packed so pc/rd fields can be appended later without touching the FIFO.
  typedef struct packed {
    logic [RETIRE_W-1:0] instr;
  } retire_rec_t;

endpackage

// File: rtl/retire_fifo.sv
// rtl/retire_fifo.sv - per-core retire FIFO with a separate level count.
module retire_fifo
  import retire_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type rec_t = retire_rec_t,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  rec_t          din_i,
  input  logic          pop_i,
  output rec_t          head_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);

  rec_t          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign empty_o   = (r_level == '0);
  assign full_o    = (r_level == LW'(DEPTH));
  assign w_pop_ok  = pop_i && !empty_o;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign w_push_ok = push_i && (!full_o || w_pop_ok);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= din_i;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_level <= r_level + LW'(w_push_ok) - LW'(w_pop_ok);
    end
  end

  assign head_o  = r_mem[r_rd_ptr];
  assign level_o = r_level;

endmodule

// File: rtl/retire_pair_buffer.sv
// rtl/retire_pair_buffer.sv - pairs two cores' retire streams; RETIRE_PAIR_MISMATCH_EN adds mismatch reporting.
module retire_pair_buffer
  import retire_pkg::*;
#(
  parameter int  DEPTH    = 4,
  parameter int  MAX_SKEW = 64,
  localparam int LW       = $clog2(DEPTH) + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                retire_1_i,
  input  logic [RETIRE_W-1:0] retire_instr_1_i,
  input  logic                retire_2_i,
  input  logic [RETIRE_W-1:0] retire_instr_2_i,
  output logic                pair_valid_o,
  input  logic                pair_ready_i,
  output logic [RETIRE_W-1:0] pair_instr_1_o,
  output logic [RETIRE_W-1:0] pair_instr_2_o,
  output logic                stall_1_o,
  output logic                stall_2_o,
  output logic                desync_o,
  output logic [LW-1:0]       level_1_o,
  output logic [LW-1:0]       level_2_o
`ifdef RETIRE_PAIR_MISMATCH_EN
  ,
  output logic                mismatch_o,
  output logic [15:0]         mismatch_cnt_o
`endif
);

  localparam int SW = $clog2(MAX_SKEW + 1);

  retire_rec_t   w_din_1, w_din_2, w_head_1, w_head_2;
  logic          w_full_1, w_full_2, w_empty_1, w_empty_2;
  logic          w_pop, w_drop_1, w_drop_2;
  logic [LW-1:0] w_lvl_nxt_1, w_lvl_nxt_2;
  logic [SW-1:0] r_skew, w_skew_nxt;
  logic          r_stall_1, r_stall_2, r_desync;

  assign w_din_1.instr = retire_instr_1_i;
  assign w_din_2.instr = retire_instr_2_i;

  retire_fifo #(.DEPTH(DEPTH), .rec_t(retire_rec_t)) u_fifo_1 (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(retire_1_i), .din_i(w_din_1), .pop_i(w_pop),
    .head_o(w_head_1), .level_o(level_1_o), .full_o(w_full_1), .empty_o(w_empty_1)
  );

  retire_fifo #(.DEPTH(DEPTH), .rec_t(retire_rec_t)) u_fifo_2 (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(retire_2_i), .din_i(w_din_2), .pop_i(w_pop),
    .head_o(w_head_2), .level_o(level_2_o), .full_o(w_full_2), .empty_o(w_empty_2)
  );

  assign pair_valid_o   = !w_empty_1 && !w_empty_2;
  assign w_pop          = pair_valid_o && pair_ready_i;
  assign pair_instr_1_o = w_head_1.instr;
  assign pair_instr_2_o = w_head_2.instr;

  assign w_drop_1    = retire_1_i && w_full_1 && !w_pop;
  assign w_drop_2    = retire_2_i && w_full_2 && !w_pop;
  assign w_lvl_nxt_1 = level_1_o + LW'(retire_1_i && !w_drop_1) - LW'(w_pop);
  assign w_lvl_nxt_2 = level_2_o + LW'(retire_2_i && !w_drop_2) - LW'(w_pop);

  always_comb begin
    w_skew_nxt = '0;
    if (w_empty_1 ^ w_empty_2) begin
      w_skew_nxt = (r_skew == SW'(MAX_SKEW)) ? r_skew : r_skew + 1'b1;
    end
  end

  // Stall one entry early so the retire already in flight still has a slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_skew    <= '0;
      r_stall_1 <= 1'b0;
      r_stall_2 <= 1'b0;
      r_desync  <= 1'b0;
    end else begin
      r_skew    <= w_skew_nxt;
      r_stall_1 <= (w_lvl_nxt_1 >= LW'(DEPTH - 1));
      r_stall_2 <= (w_lvl_nxt_2 >= LW'(DEPTH - 1));
      r_desync  <= r_desync || w_drop_1 || w_drop_2 || (w_skew_nxt == SW'(MAX_SKEW));
    end
  end

  assign stall_1_o = r_stall_1;
  assign stall_2_o = r_stall_2;
  assign desync_o  = r_desync;

`ifdef RETIRE_PAIR_MISMATCH_EN
  logic        w_mismatch;
  logic        r_mismatch;
  logic [15:0] r_mismatch_cnt;

  assign w_mismatch = w_pop && (w_head_1 != w_head_2);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mismatch     <= 1'b0;
      r_mismatch_cnt <= '0;
    end else begin
      r_mismatch <= w_mismatch;
      if (w_mismatch && (r_mismatch_cnt != 16'hFFFF)) begin
        r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
      end
    end
  end

  assign mismatch_o     = r_mismatch;
  assign mismatch_cnt_o = r_mismatch_cnt;
`endif

endmodule

// File: tb/tb_retire_pair_buffer.sv
// tb/tb_retire_pair_buffer.sv - randomized queue-model bench with directed literal checks.
module tb_retire_pair_buffer;

  localparam int DEPTH    = 4;
  localparam int MAX_SKEW = 8;
  localparam int LW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, r1, r2, ready;
  logic [31:0]   i1, i2;
  logic          valid, stall_1, stall_2, desync;
  logic [31:0]   p1, p2;
  logic [LW-1:0] level_1, level_2;
`ifdef RETIRE_PAIR_MISMATCH_EN
  logic          mismatch;
  logic [15:0]   mismatch_cnt;
`endif

  retire_pair_buffer #(.DEPTH(DEPTH), .MAX_SKEW(MAX_SKEW)) dut (
    .clk_i(clk), .rst_i(rst),
    .retire_1_i(r1), .retire_instr_1_i(i1),
    .retire_2_i(r2), .retire_instr_2_i(i2),
    .pair_valid_o(valid), .pair_ready_i(ready),
    .pair_instr_1_o(p1), .pair_instr_2_o(p2),
    .stall_1_o(stall_1), .stall_2_o(stall_2), .desync_o(desync),
    .level_1_o(level_1), .level_2_o(level_2)
`ifdef RETIRE_PAIR_MISMATCH_EN
    , .mismatch_o(mismatch), .mismatch_cnt_o(mismatch_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  // Behavioural model: two queues of instruction words plus flags.
  logic [31:0] q1[$], q2[$];
  int  m_skew = 0;
  int  s1, s2;
  bit  m_pop;
  bit  m_desync = 0, m_stall1 = 0, m_stall2 = 0, m_live = 0;
  bit  m_mis = 0;
  int  m_mis_cnt = 0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      q1.delete(); q2.delete();
      m_skew = 0; m_desync = 0; m_stall1 = 0; m_stall2 = 0;
      m_mis = 0; m_mis_cnt = 0; m_live = 1;
    end else begin
      s1 = q1.size(); s2 = q2.size();
      m_pop = (s1 > 0) && (s2 > 0) && ready;
      m_mis = m_pop && (q1[0] != q2[0]);
      if (m_mis && m_mis_cnt < 65535) m_mis_cnt++;
      if (m_pop) begin
        void'(q1.pop_front());
        void'(q2.pop_front());
      end
      if (r1) begin
        if (s1 == DEPTH && !m_pop) m_desync = 1; else q1.push_back(i1);
      end
      if (r2) begin
        if (s2 == DEPTH && !m_pop) m_desync = 1; else q2.push_back(i2);
      end
      if ((s1 > 0) != (s2 > 0)) m_skew = (m_skew < MAX_SKEW) ? m_skew + 1 : MAX_SKEW;
      else m_skew = 0;
      if (m_skew == MAX_SKEW) m_desync = 1;
      m_stall1 = q1.size() >= DEPTH - 1;
      m_stall2 = q2.size() >= DEPTH - 1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("level_1", 32'(level_1), 32'(q1.size()));
      chk("level_2", 32'(level_2), 32'(q2.size()));
      chk("pair_valid", 32'(valid), 32'((q1.size() > 0) && (q2.size() > 0)));
      if (q1.size() > 0 && q2.size() > 0) begin
        chk("pair_instr_1", p1, q1[0]);
        chk("pair_instr_2", p2, q2[0]);
      end
      chk("stall_1", 32'(stall_1), 32'(m_stall1));
      chk("stall_2", 32'(stall_2), 32'(m_stall2));
      chk("desync", 32'(desync), 32'(m_desync));
`ifdef RETIRE_PAIR_MISMATCH_EN
      chk("mismatch", 32'(mismatch), 32'(m_mis));
      chk("mismatch_cnt", 32'(mismatch_cnt), 32'(m_mis_cnt));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1; r1 = 0; r2 = 0; ready = 0;
    step();
    rst = 0;
  endtask

  initial begin
    rst = 1; r1 = 0; r2 = 0; ready = 0; i1 = '0; i2 = '0;
    @(negedge clk);
    step();
    rst = 0;
    chk("rst_level_1", 32'(level_1), 32'd0);
    chk("rst_level_2", 32'(level_2), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_instr_1", p1, 32'd0);
    chk("rst_instr_2", p2, 32'd0);
    chk("rst_stall", 32'({stall_1, stall_2, desync}), 32'd0);

    // Lock-step pair.
    r1 = 1; r2 = 1; i1 = 32'h13; i2 = 32'h13; ready = 1;
    step();
    r1 = 0; r2 = 0;
    chk("ls_valid", 32'(valid), 32'd1);
    chk("ls_instr_1", p1, 32'h13);
    chk("ls_instr_2", p2, 32'h13);
    chk("ls_stall", 32'({stall_1, stall_2}), 32'd0);
    step();
    chk("ls_drained", 32'({level_1, level_2, valid}), 32'd0);

    // Skewed fill then wrap with simultaneous push and pop on a full FIFO.
    reset_dut();
    r1 = 1; i1 = 32'h1; step();
    i1 = 32'h2; step();
    i1 = 32'h3; step();
    r1 = 0;
    chk("skf_stall_1", 32'(stall_1), 32'd1);
    chk("skf_level_1", 32'(level_1), 32'd3);
    chk("skf_valid", 32'(valid), 32'd0);
    r2 = 1; i2 = 32'hA; step();
    r2 = 0;
    chk("skf_pair_valid", 32'(valid), 32'd1);
    chk("skf_pair_1", p1, 32'h1);
    chk("skf_pair_2", p2, 32'hA);
    r1 = 1; i1 = 32'h4; step();
    chk("full_level_1", 32'(level_1), 32'd4);
    ready = 1; i1 = 32'h5; r2 = 1; i2 = 32'hB; step();
    r1 = 0;
    chk("full_pp_level_1", 32'(level_1), 32'd4);
    chk("full_pp_head_1", p1, 32'h2);
    chk("full_pp_head_2", p2, 32'hB);
    i2 = 32'hC; step();
    chk("wrap_head_3", p1, 32'h3);
    i2 = 32'hD; step();
    chk("wrap_head_4", p1, 32'h4);
    i2 = 32'hE; step();
    chk("wrap_head_5", p1, 32'h5);
    chk("wrap_head_e", p2, 32'hE);
    r2 = 0; step();
    chk("wrap_empty", 32'(level_1), 32'd0);

    // Skew timeout.
    reset_dut();
    r2 = 1; i2 = 32'h77; step();
    r2 = 0;
    repeat (MAX_SKEW - 1) step();
    chk("skew_before", 32'(desync), 32'd0);
    step();
    chk("skew_at", 32'(desync), 32'd1);
    repeat (3) step();
    chk("skew_sticky", 32'(desync), 32'd1);

    // Reset mid-operation, with a retire pulse in the reset cycle.
    r1 = 1; r2 = 1; i1 = $urandom; i2 = $urandom; step();
    i1 = $urandom; i2 = $urandom; step();
    r1 = 0; r2 = 0;
    chk("mid_level_1", 32'(level_1), 32'd2);
    rst = 1; r1 = 1; step();
    rst = 0; r1 = 0;
    chk("mid_rst_levels", 32'({level_1, level_2}), 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_flags", 32'({stall_1, stall_2, desync}), 32'd0);

    // Overflow drops the record and sets desync.
    r1 = 1;
    for (int k = 0; k < DEPTH + 1; k++) begin
      i1 = 32'h100 + 32'(k);
      step();
    end
    r1 = 0;
    chk("ovf_level_1", 32'(level_1), 32'(DEPTH));
    chk("ovf_desync", 32'(desync), 32'd1);

`ifdef RETIRE_PAIR_MISMATCH_EN
    reset_dut();
    ready = 1; r1 = 1; r2 = 1; i1 = 32'h13; i2 = 32'h00100093; step();
    r1 = 0; r2 = 0; step();
    chk("mis_pulse", 32'(mismatch), 32'd1);
    chk("mis_cnt", 32'(mismatch_cnt), 32'd1);
    step();
    chk("mis_pulse_end", 32'(mismatch), 32'd0);
    r1 = 1; r2 = 1; i1 = 32'h13; i2 = 32'h13; step();
    r1 = 0; r2 = 0; step();
    chk("eq_pulse", 32'(mismatch), 32'd0);
    chk("eq_cnt", 32'(mismatch_cnt), 32'd1);
`endif

    // Randomized traffic, mostly honouring stalls.
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      r1    = ($urandom_range(0, 2) != 0) && (!stall_1 || $urandom_range(0, 49) == 0);
      r2    = ($urandom_range(0, 2) != 0) && (!stall_2 || $urandom_range(0, 49) == 0);
      i1    = ($urandom_range(0, 1) == 0) ? 32'h13 : $urandom;
      i2    = ($urandom_range(0, 1) == 0) ? 32'h13 : $urandom;
      ready = ($urandom_range(0, 1) == 0);
      step();
    end
    rst = 0; r1 = 0; r2 = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
